frame_deserializer: RTL and testbench

Receive side of the HEADER/data/FOOTER byte-stream framing used by the channel serializer. Hunts for header byte 0xAA, captures NUM_CHANNELS data bytes into a shadow buffer, and checks for footer byte 0xFF. On a good frame it publishes all channels in parallel on a flat bus with a one-cycle valid pulse. On a bad footer it discards the frame and pulses an error.

---
 rtl/frame_pkg.sv | 21 ++
 rtl/frame_deserializer.sv | 136 +++++++++++++
 tb/tb_frame_deserializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// ============================================================================
// frame_pkg : framing constants and receive-state encoding shared by both ends
// Revision  : 1.0
// ============================================================================
`default_nettype none

package frame_pkg;

  localparam logic [7:0] FRAME_HEADER       = 8'hAA;
  localparam logic [7:0] FRAME_FOOTER       = 8'hFF;
  localparam int         FRAME_NUM_CHANNELS = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_FOOTER = 2'd2
  } rx_state_e;

endpackage : frame_pkg

`default_nettype wire

// File: rtl/frame_deserializer.sv
// ============================================================================
// frame_deserializer : HEADER/data/FOOTER byte-stream receiver, parallel output
// Optional: define FRAME_ERR_CNT_EN to add a saturating 16-bit err_count port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_deserializer
  import frame_pkg::*;
#(
  parameter logic [7:0] HEADER       = FRAME_HEADER,
  parameter logic [7:0] FOOTER       = FRAME_FOOTER,
  parameter int         NUM_CHANNELS = FRAME_NUM_CHANNELS,
  parameter int         CW           = $clog2(NUM_CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                din,
  input  logic                      din_valid,
  output logic [8*NUM_CHANNELS-1:0] frame_data,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      busy,
  output logic [CW-1:0]             ch_cnt
`ifdef FRAME_ERR_CNT_EN
  ,
  output logic [15:0]               err_count
`endif
);

  localparam logic [CW-1:0] C_LAST_CH = CW'(NUM_CHANNELS - 1);

  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             ch_cnt_q, ch_cnt_d;
  logic [8*NUM_CHANNELS-1:0] shadow_q, shadow_d;
  logic [8*NUM_CHANNELS-1:0] frame_data_q, frame_data_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ch_cnt_q      <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_cnt_q      <= ch_cnt_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ch_cnt_d      = ch_cnt_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (din_valid && (din == HEADER)) begin
          state_d  = ST_DATA;
          ch_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (din_valid) begin
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (ch_cnt_q == CW'(k)) begin
              shadow_d[8*k +: 8] = din;
            end
          end
          // Counter parks on the last index so it never leaves 0..NUM_CHANNELS-1.
          if (ch_cnt_q == C_LAST_CH) begin
            state_d = ST_FOOTER;
          end else begin
            ch_cnt_d = ch_cnt_q + CW'(1);
          end
        end
      end

      ST_FOOTER: begin
        if (din_valid) begin
          ch_cnt_d = '0;
          if (din == FOOTER) begin
            frame_data_d  = shadow_q;
            frame_valid_d = 1'b1;
            state_d       = ST_IDLE;
          end else if (din == HEADER) begin
            frame_err_d = 1'b1;
            state_d     = ST_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        ch_cnt_d = '0;
      end
    endcase
  end

`ifdef FRAME_ERR_CNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (frame_err_d && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`endif

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != ST_IDLE);
  assign ch_cnt      = ch_cnt_q;

endmodule : frame_deserializer

`default_nettype wire

// File: tb/tb_frame_deserializer.sv
// ============================================================================
// tb_frame_deserializer : directed stimulus with a queue-based reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_deserializer;

  localparam int N  = 16;
  localparam int CW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       din;
  logic             din_valid;
  logic [8*N-1:0]   frame_data;
  logic             frame_valid;
  logic             frame_err;
  logic             busy;
  logic [CW-1:0]    ch_cnt;
`ifdef FRAME_ERR_CNT_EN
  logic [15:0]      err_count;
`endif

  int checks = 0;
  int errors = 0;

  frame_deserializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .ch_cnt      (ch_cnt)
`ifdef FRAME_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [8*N-1:0] act, input logic [8*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collected bytes in a queue, frame decisions from counts.
  bit             m_in_frame = 1'b0;
  logic [7:0]     m_buf[$];
  logic [8*N-1:0] m_data  = '0;
  bit             m_valid = 1'b0;
  bit             m_err   = 1'b0;
  int             m_errcnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst_n !== 1'b1) begin
      m_in_frame = 1'b0;
      m_buf.delete();
      m_data   = '0;
      m_errcnt = 0;
    end else if (din_valid === 1'b1) begin
      if (!m_in_frame) begin
        if (din == 8'hAA) begin
          m_in_frame = 1'b1;
          m_buf.delete();
        end
      end else if (m_buf.size() < N) begin
        m_buf.push_back(din);
      end else begin
        if (din == 8'hFF) begin
          for (int k = 0; k < N; k++) m_data[8*k +: 8] = m_buf[k];
          m_valid    = 1'b1;
          m_in_frame = 1'b0;
        end else begin
          m_err      = 1'b1;
          m_in_frame = (din == 8'hAA);
          if (m_errcnt < 65535) m_errcnt++;
        end
        m_buf.delete();
      end
    end
  end

  function automatic int m_cnt();
    if (!m_in_frame) return 0;
    return (m_buf.size() < N) ? m_buf.size() : N - 1;
  endfunction

  // Per-cycle comparison and pulse counting.
  int vpulses = 0;
  int epulses = 0;

  initial forever begin
    @(negedge clk);
    chk("cyc_frame_data",  frame_data,        m_data);
    chk("cyc_frame_valid", {127'd0, frame_valid}, {127'd0, m_valid});
    chk("cyc_frame_err",   {127'd0, frame_err},   {127'd0, m_err});
    chk("cyc_busy",        {127'd0, busy},        {127'd0, m_in_frame});
    chk("cyc_ch_cnt",      {{(8*N-CW){1'b0}}, ch_cnt}, (8*N)'(m_cnt()));
`ifdef FRAME_ERR_CNT_EN
    chk("cyc_err_count",   {112'd0, err_count},   (8*N)'(m_errcnt));
`endif
    if (frame_valid === 1'b1) vpulses++;
    if (frame_err === 1'b1)   epulses++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    din       = b;
    din_valid = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    din       = 8'hAA;
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int step, input logic [7:0] ftr, input bit gaps);
    send(8'hAA);
    if (gaps) gap();
    for (int k = 0; k < N; k++) begin
      send(8'(base + step * k));
      if (gaps) gap();
    end
    send(ftr);
  endtask

  function automatic logic [8*N-1:0] pat(input int base, input int step);
    logic [8*N-1:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = 8'(base + step * k);
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_frame_data",  frame_data, '0);
    chk("rst_frame_valid", {127'd0, frame_valid}, '0);
    chk("rst_busy",        {127'd0, busy}, '0);
    chk("rst_ch_cnt",      {{(8*N-CW){1'b0}}, ch_cnt}, '0);
    rst_n = 1'b1;
    gap();

    // Contiguous good frame
    send_frame(0, 1, 8'hFF, 1'b0);
    gap();
    chk("good_valid",  {127'd0, frame_valid}, 128'd1);
    chk("good_ch0",    {120'd0, frame_data[7:0]},     128'h00);
    chk("good_ch15",   {120'd0, frame_data[127:120]}, 128'h0F);
    chk("good_noerr",  {127'd0, frame_err}, '0);

    // Same frame with gaps everywhere
    vpulses = 0;
    send_frame(0, 1, 8'hFF, 1'b1);
    repeat (3) gap();
    chk("gap_data",   frame_data, pat(0, 1));
    chk("gap_pulses", 128'(vpulses), 128'd1);

    // Bad footer keeps previous frame
    epulses = 0;
    send_frame(8'h55, 0, 8'h12, 1'b0);
    gap();
    chk("bad_err",   {127'd0, frame_err}, 128'd1);
    chk("bad_valid", {127'd0, frame_valid}, '0);
    chk("bad_keep",  frame_data, pat(0, 1));
    chk("bad_idle",  {127'd0, busy}, '0);
`ifdef FRAME_ERR_CNT_EN
    chk("bad_errcnt", {112'd0, err_count}, 128'd1);
`endif

    // Header in footer slot resyncs into the next frame
    epulses = 0;
    vpulses = 0;
    send(8'hAA);
    for (int k = 0; k < N; k++) send(8'h44);
    send_frame(8'h33, 0, 8'hFF, 1'b0);
    gap();
    chk("resync_valid",  {127'd0, frame_valid}, 128'd1);
    chk("resync_data",   frame_data, {N{8'h33}});
    gap();
    chk("resync_errs",   128'(epulses), 128'd1);
    chk("resync_valids", 128'(vpulses), 128'd1);

    // Idle noise then back-to-back frames
    vpulses = 0;
    epulses = 0;
    send(8'h01); send(8'hFF); send(8'h7E);
    gap();
    chk("noise_busy", {127'd0, busy}, '0);
    send_frame(8'h10, 1, 8'hFF, 1'b0);
    send_frame(8'hF0, -3, 8'hFF, 1'b0);
    repeat (2) gap();
    chk("b2b_valids", 128'(vpulses), 128'd2);
    chk("b2b_errs",   128'(epulses), 128'd0);
    chk("b2b_data",   frame_data, pat(8'hF0, -3));
    chk("b2b_ch1",    {120'd0, frame_data[15:8]}, 128'hED);

    // Reset mid-frame
    send(8'hAA);
    for (int k = 0; k < 7; k++) send(8'(8'h80 + k));
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_data",  frame_data, '0);
    chk("mrst_busy",  {127'd0, busy}, '0);
    chk("mrst_cnt",   {{(8*N-CW){1'b0}}, ch_cnt}, '0);
    chk("mrst_valid", {127'd0, frame_valid}, '0);
    rst_n = 1'b1;
    gap();
    send(8'hAA);
    send(8'h21);
    gap();
    chk("mrst_cnt1",  {{(8*N-CW){1'b0}}, ch_cnt}, 128'd1);
    for (int k = 1; k < N; k++) send(8'(8'h21 + k));
    send(8'hFF);
    gap();
    chk("mrst_frame", frame_data, pat(8'h21, 1));
    repeat (2) gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_frame_deserializer

`default_nettype wire
